// File: rtl/sprite_rom_arbiter.sv
// Four-requester round-robin arbiter for a single sprite ROM port with bounded bursts.
// Define SPRITE_ARB_TRANSP_EN to build the transparent-colour flag on the read return.
module sprite_rom_arbiter #(
    parameter int          BURST_LEN  = 8,
    parameter logic [11:0] TRANSP_KEY = 12'h6CC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [19:0] req_row,
    input  logic [19:0] req_col,
    output logic [3:0]  gnt,
    output logic [4:0]  rom_row,
    output logic [4:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic [3:0]  rd_valid,
    output logic [11:0] rd_data,
    output logic        rd_transp,
    output logic        busy
);
    if (BURST_LEN < 1 || BURST_LEN > 32 || $bits(TRANSP_KEY) != 12) begin : g_param_chk
        $error("sprite_rom_arbiter: BURST_LEN must be 1..32");
    end

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [4:0] CNT_MAX = 5'(BURST_LEN - 1);

    state_t     state, state_nx;
    logic [1:0] owner, owner_nx;
    logic [1:0] last_owner, last_nx;
    logic [4:0] cnt, cnt_nx;
    logic [1:0] pick, idx;
    logic       pick_vld;
    logic       beat, burst_end;

    assign beat      = (state == OWN) && req[owner];
    assign burst_end = (state == OWN) && (!req[owner] || cnt == CNT_MAX);

    // Descending scan so the nearest requester after last_owner wins; k=4 wraps to last_owner.
    always_comb begin
        pick     = last_owner;
        pick_vld = 1'b0;
        idx      = last_owner;
        for (int k = 4; k >= 1; k--) begin
            idx = last_owner + 2'(k);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last_owner;
        cnt_nx   = cnt;
        if (state == IDLE || burst_end) begin
            cnt_nx = 5'd0;
            if (pick_vld) begin
                state_nx = OWN;
                owner_nx = pick;
                last_nx  = pick;
            end else begin
                state_nx = IDLE;
            end
        end else if (beat) begin
            cnt_nx = cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd3;
            cnt        <= 5'd0;
            rd_valid   <= 4'b0000;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
            cnt        <= cnt_nx;
            rd_valid   <= beat ? gnt : 4'b0000;
        end
    end

    assign busy    = (state == OWN);
    assign gnt     = busy ? (4'b0001 << owner) : 4'b0000;
    assign rom_row = busy ? req_row[owner*5 +: 5] : 5'd0;
    assign rom_col = busy ? req_col[owner*5 +: 5] : 5'd0;
    assign rd_data = rom_data;

`ifdef SPRITE_ARB_TRANSP_EN
    assign rd_transp = (|rd_valid) && (rd_data == TRANSP_KEY);
`else
    assign rd_transp = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed and randomized bench for sprite_rom_arbiter against a cycle-level
// transaction model (owner, beats-in-burst, last owner, pending read return).
module tb_sprite_rom_arbiter;
    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [19:0] req_row, req_col;
    logic [3:0]  gnt, rd_valid;
    logic [4:0]  rom_row, rom_col;
    logic [11:0] rom_data, rd_data, rom_q;
    logic        rd_transp, busy;

    sprite_rom_arbiter #(.BURST_LEN(BL), .TRANSP_KEY(12'h6CC)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_row(req_row), .req_col(req_col),
        .gnt(gnt), .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_transp(rd_transp), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [4:0] r, input logic [4:0] c);
        if (r == 5'd7 && c == 5'd7) return 12'h6CC;
        return {r[3:0], c[3:0], r[4], c[4], 2'b00};
    endfunction

    // ROM: data one cycle after the address
    always @(posedge clk) rom_q <= rom_fn(rom_row, rom_col);
    assign rom_data = rom_q;

    int npass = 0, ntot = 0;

    // model state
    bit          m_act;
    int          m_own, m_beats, m_last;
    logic [3:0]  m_rdv;
    logic [11:0] m_rdd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_act = 0; m_own = 0; m_beats = 0; m_last = 3; m_rdv = 4'b0; m_rdd = 12'h0;
    endtask

    task automatic cycle(input logic [3:0] r, input logic [19:0] rows, input logic [19:0] cols);
        logic [3:0] eg;
        logic [4:0] er, ec;
        bit beat, rearb, found;
        @(negedge clk);
        req = r; req_row = rows; req_col = cols;
        #1;
        eg = m_act ? 4'(1 << m_own) : 4'b0;
        er = m_act ? rows[m_own*5 +: 5] : 5'd0;
        ec = m_act ? cols[m_own*5 +: 5] : 5'd0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(m_act));
        chk("rom_row", 32'(rom_row), 32'(er));
        chk("rom_col", 32'(rom_col), 32'(ec));
        chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
        if (m_rdv != 4'b0) chk("rd_data", 32'(rd_data), 32'(m_rdd));
`ifdef SPRITE_ARB_TRANSP_EN
        chk("rd_transp", 32'(rd_transp), 32'((m_rdv != 4'b0) && m_rdd == 12'h6CC));
`else
        chk("rd_transp", 32'(rd_transp), 32'(0));
`endif
        // advance the model across the coming rising edge
        beat  = m_act && r[m_own];
        m_rdv = beat ? 4'(1 << m_own) : 4'b0;
        m_rdd = rom_fn(er, ec);
        if (!m_act || !beat) rearb = 1;
        else if (m_beats + 1 == BL) rearb = 1;
        else begin m_beats++; rearb = 0; end
        if (rearb) begin
            found = 0;
            for (int k = 1; k <= 4 && !found; k++) begin
                if (r[(m_last + k) % 4]) begin
                    found = 1; m_own = (m_last + k) % 4; m_last = m_own;
                end
            end
            m_act = found; m_beats = 0;
        end
    endtask

    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        req = 4'b0;
        model_reset();
        @(negedge clk) reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; req = 4'b0; req_row = 20'h0; req_col = 20'h0;
        model_reset();
        @(negedge clk); #1;
        chk("init_gnt", 32'(gnt), 32'(0));
        chk("init_rd_valid", 32'(rd_valid), 32'(0));
        chk("init_busy", 32'(busy), 32'(0));
        @(negedge clk) reset_n = 1'b1;

        // idle
        for (int i = 0; i < 10; i++) cycle(4'b0000, $urandom, $urandom);
        // single requester 2, row 3, col 9..
        for (int i = 0; i < 14; i++) cycle(4'b0100, 20'(3) << 10, 20'(9 + i) << 10);
        // all requesting: round robin, then reset mid-burst
        reset_pulse();
        for (int i = 0; i < 14; i++) cycle(4'b1111, $urandom, $urandom);
        reset_pulse();
        for (int i = 0; i < 6; i++) cycle(4'b1111, $urandom, $urandom);
        // early release: owner 1 drops after 3 beats while 2 waits
        reset_pulse();
        cycle(4'b0010, $urandom, $urandom);
        for (int i = 0; i < 3; i++) cycle(4'b0110, $urandom, $urandom);
        for (int i = 0; i < 4; i++) cycle(4'b0100, $urandom, $urandom);
        // transparency key then black from requester 0
        for (int i = 0; i < 6; i++)
            cycle(4'b0001, (i % 2 == 0) ? 20'd7 : 20'd0, (i % 2 == 0) ? 20'd7 : 20'd0);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 20'd0, 20'd0);
        // random traffic with sticky requests
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = (i % 8 < 6) ? req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & 4'h5)
                            : 4'($urandom);
            if (i == 200) reset_pulse();
            cycle(r, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter: BURST_LEN, 8, max consecutive beats one owner holds the ROM port; legal range 1..32.
REQ-002 Parameter: TRANSP_KEY, 12'h6CC, colour treated as transparent background.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  4  per-requester access request; bit i belongs to requester i.
REQ-006 req_row  input  20  requester i row address at bits [5i+4:5i].
REQ-007 req_col  input  20  requester i column address at bits [5i+4:5i].
REQ-008 gnt  output  4  one-hot registered grant; all-zero when idle.
REQ-009 rom_row  output  5  row address driven to the sprite ROM.
REQ-010 rom_col  output  5  column address driven to the sprite ROM.
REQ-011 rom_data  input  12  ROM colour, valid one cycle after the address is presented.
REQ-012 rd_valid  output  4  one-hot; bit i marks rd_data as requester i's pixel.
REQ-013 rd_data  output  12  returned colour (RGB 4:4:4).
REQ-014 rd_transp  output  1  rd_data equals TRANSP_KEY (see Configuration).
REQ-015 busy  output  1  high whenever gnt is non-zero.

Function
REQ-016 States: IDLE (gnt=0) and OWN (gnt one-hot); the owner index and a 5-bit beat counter are registered.
REQ-017 Beat: a cycle where gnt[i] and req[i] are both high; exactly one ROM access per beat.
REQ-018 rom_row/rom_col: combinational mux of the owner's req_row/req_col while in OWN; 0 in IDLE.
REQ-019 IDLE -> OWN: when req is non-zero at a clock edge, gnt asserts in the next cycle; one-cycle request-to-grant latency.
REQ-020 Selection: round-robin, searching from (last_owner+1) mod 4 upward; the first set req bit wins.
REQ-021 Burst end: on the beat where the counter equals BURST_LEN-1, or on any OWN cycle where req[owner] is low.
REQ-022 At burst end, re-arbitrate in the same edge with no bubble: another requester present -> grant it; only the owner requesting -> re-grant the owner with the counter cleared; none -> IDLE.
REQ-023 A cycle with req[owner] low produces no beat, no rd_valid, and no counter increment.
REQ-024 Counter: clears on every new grant and increments on each beat; it never exceeds BURST_LEN-1.
REQ-025 Read return: rd_valid is the beat one-hot registered by one cycle; rd_data is rom_data combinationally, so rd_valid and rd_data align exactly one cycle after the beat.
REQ-026 Return after ownership change: a beat in the last cycle of a burst still returns rd_valid for the old owner in the next cycle, concurrent with the new owner's gnt.
REQ-027 Requester addresses are not latched by the arbiter; a requester holds row/col stable only during its own beat cycle.
REQ-028 Simultaneous requests: fairness bound; any continuously requesting requester is granted within 3*BURST_LEN+3 cycles.

Reset
REQ-029 While reset_n is low: state IDLE, gnt=0, busy=0, rd_valid=0, counter=0, last_owner=3 (requester 0 has priority first).
REQ-030 Reset asserted mid-burst clears immediately; no rd_valid is generated for the interrupted beat.
REQ-031 The first grant is possible in the first cycle after the first rising edge following reset_n deassertion.

Configuration
REQ-032 Macro SPRITE_ARB_TRANSP_EN defined: rd_transp = (|rd_valid) & (rd_data == TRANSP_KEY).
REQ-033 Macro SPRITE_ARB_TRANSP_EN undefined: rd_transp is tied to 0, no comparator is built, and TRANSP_KEY is unused.

Verification
REQ-034 Reset: drive reset_n low during a burst with req=4'b1111 -> gnt=0, rd_valid=0, busy=0 immediately; after release, the first gnt is 4'b0001.
REQ-035 Single requester: req=4'b0100 held, row=3, col=9..; BURST_LEN=8 -> gnt=4'b0100 continuous, rom_row=3, rd_valid=4'b0100 every cycle from cycle 2, no bubble at re-grant.
REQ-036 Round-robin: req=4'b1111 held, BURST_LEN=2 -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001.
REQ-037 Early release: owner 1 drops req after 3 beats while req[2]=1 -> exactly 3 rd_valid=4'b0010 pulses, then gnt=4'b0100 on the next edge.
REQ-038 Transparency: with SPRITE_ARB_TRANSP_EN, ROM returns 12'h6CC then 12'h000 -> rd_transp=1 then 0; with the macro undefined, rd_transp=0 throughout.
REQ-039 Idle: req=0 for 10 cycles -> gnt=0, rom_row=rom_col=0, rd_valid=0.
